// File: rtl/sdrc_req_pkg.sv
// sdrc_req_pkg: shared types and field widths for the SDRAM request splitter
package sdrc_req_pkg;
  localparam int ROW_W  = 12;
  localparam int BANK_W = 2;
  localparam int COL_W  = 12;
  localparam int LEN_W  = 9;
  typedef enum logic [1:0] {CB_8, CB_9, CB_10, CB_11} colbits_t;
  typedef enum logic {IDLE, ISSUE} state_t;
endpackage

// File: rtl/sdrc_addr_decode.sv
// sdrc_addr_decode: splits a word address into row/bank/col and words left in the page
module sdrc_addr_decode
  import sdrc_req_pkg::*;
#(
  parameter int APP_AW = 26
) (
  input  colbits_t           colbits,
  input  logic [APP_AW-1:0]  addr,
  output logic [ROW_W-1:0]   row,
  output logic [BANK_W-1:0]  bank,
  output logic [COL_W-1:0]   col,
  output logic [COL_W-1:0]   page_rem
);
  logic [3:0] c;
  logic [COL_W:0] psize;
  assign c = 4'd8 + {2'b00, colbits};
  assign psize = (COL_W+1)'(1) << c;
  assign col = COL_W'(addr) & (psize[COL_W-1:0] - COL_W'(1));
  assign {row, bank} = (ROW_W+BANK_W)'(addr >> c);
  assign page_rem = COL_W'(psize - {1'b0, col});
endmodule

// File: rtl/sdrc_req_split.sv
// sdrc_req_split: breaks application requests into page-bounded SDRAM sub-requests
module sdrc_req_split
  import sdrc_req_pkg::*;
#(
  parameter int APP_AW = 26,
  parameter int RQ_LW  = 8
) (
  input  logic               sdram_clk,
  input  logic               sdram_rst,
  input  logic [1:0]         cfg_colbits,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [APP_AW-1:0]  in_addr,
  input  logic [RQ_LW-1:0]   in_len,
  input  logic               in_wr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ROW_W-1:0]   out_row,
  output logic [BANK_W-1:0]  out_bank,
  output logic [COL_W-1:0]   out_col,
  output logic [LEN_W-1:0]   out_len,
  output logic               out_wr,
  output logic               out_last
);
  state_t state;
  colbits_t cb_q, dec_cb;
  logic idle;
  logic [APP_AW-1:0] addr_q, dec_addr;
  logic [LEN_W-1:0] rem_q, dec_rem, len_in, sub_len;
  logic [ROW_W-1:0] d_row;
  logic [BANK_W-1:0] d_bank;
  logic [COL_W-1:0] d_col, d_pr;
  assign idle = state == IDLE;
  assign in_ready = idle && !sdram_rst;
  assign len_in = (in_len == '0) ? LEN_W'(1) << RQ_LW : LEN_W'(in_len);
  // one decoder serves both the incoming request and the next sub-request address
  assign dec_cb = idle ? colbits_t'(cfg_colbits) : cb_q;
  assign dec_addr = idle ? in_addr : addr_q + APP_AW'(out_len);
  assign dec_rem = idle ? len_in : rem_q - out_len;
  assign sub_len = (COL_W'(dec_rem) < d_pr) ? dec_rem : LEN_W'(d_pr);
  sdrc_addr_decode #(.APP_AW(APP_AW)) u_dec (
    .colbits(dec_cb), .addr(dec_addr),
    .row(d_row), .bank(d_bank), .col(d_col), .page_rem(d_pr)
  );
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state <= IDLE;
      cb_q <= CB_8;
      addr_q <= '0;
      rem_q <= '0;
      out_valid <= 1'b0;
      out_row <= '0;
      out_bank <= '0;
      out_col <= '0;
      out_len <= '0;
      out_wr <= 1'b0;
      out_last <= 1'b0;
    end else if (idle ? in_valid : out_ready) begin
      if (!idle && out_last) begin
        state <= IDLE;
        out_valid <= 1'b0;
      end else begin
        state <= ISSUE;
        out_valid <= 1'b1;
        cb_q <= dec_cb;
        addr_q <= dec_addr;
        rem_q <= dec_rem;
        out_row <= d_row;
        out_bank <= d_bank;
        out_col <= d_col;
        out_len <= sub_len;
        out_wr <= idle ? in_wr : out_wr;
        out_last <= sub_len == dec_rem;
      end
    end
  end
endmodule

// File: tb/tb_sdrc_req_split.sv
// tb_sdrc_req_split: directed vectors for the request splitter
module tb_sdrc_req_split;
  logic sdram_clk = 1'b0, sdram_rst = 1'b1;
  logic [1:0] cfg_colbits = 2'b00;
  logic in_valid = 1'b0, in_wr = 1'b0, out_ready = 1'b1;
  logic [25:0] in_addr = '0;
  logic [7:0] in_len = '0;
  logic in_ready, out_valid, out_wr, out_last;
  logic [11:0] out_row, out_col;
  logic [1:0] out_bank;
  logic [8:0] out_len;
  int n_chk = 0, n_pass = 0;

  always #5 sdram_clk = ~sdram_clk;

  sdrc_req_split dut (
    .sdram_clk(sdram_clk), .sdram_rst(sdram_rst), .cfg_colbits(cfg_colbits),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_len(in_len),
    .in_wr(in_wr), .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_bank(out_bank), .out_col(out_col), .out_len(out_len), .out_wr(out_wr),
    .out_last(out_last)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // drive a request at a negedge; it is captured on the following posedge
  task automatic issue(input logic [1:0] cb, input logic [25:0] a, input logic [7:0] l, input logic w);
    cfg_colbits = cb;
    in_addr = a;
    in_len = l;
    in_wr = w;
    in_valid = 1'b1;
    @(posedge sdram_clk);
    @(negedge sdram_clk);
    in_valid = 1'b0;
    cfg_colbits = ~cb;
  endtask

  task automatic sub(input string tag, input logic [11:0] row, input logic [1:0] bank,
                     input logic [11:0] col, input logic [8:0] len, input logic last, input logic w);
    chk(tag, {out_valid, out_row, out_bank, out_col, out_len, out_last, out_wr},
        {1'b1, row, bank, col, len, last, w});
    chk({tag, "_rdy"}, in_ready, 1'b0);
    @(negedge sdram_clk);
  endtask

  task automatic idle_chk(input string tag);
    chk(tag, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    in_valid = 1'b1;
    in_addr = 26'h0001A05;
    in_len = 8'd4;
    repeat (3) @(posedge sdram_clk);
    @(negedge sdram_clk);
    chk("rst_out", {out_valid, out_row, out_bank, out_col, out_len, out_wr, out_last}, '0);
    chk("rst_rdy", in_ready, 1'b0);
    in_valid = 1'b0;
    sdram_rst = 1'b0;
    @(negedge sdram_clk);
    idle_chk("post_rst");

    issue(2'b00, 26'h0001A05, 8'd4, 1'b1);
    sub("r38", 12'h006, 2'd2, 12'h005, 9'd4, 1'b1, 1'b1);
    idle_chk("r38_done");

    issue(2'b00, 26'h00000FC, 8'd8, 1'b0);
    sub("r39a", 12'h000, 2'd0, 12'h0FC, 9'd4, 1'b0, 1'b0);
    sub("r39b", 12'h000, 2'd1, 12'h000, 9'd4, 1'b1, 1'b0);
    idle_chk("r39_done");

    issue(2'b11, 26'h3FFFFFE, 8'd4, 1'b1);
    sub("r40a", 12'hFFF, 2'd3, 12'h7FE, 9'd2, 1'b0, 1'b1);
    sub("r40b", 12'h000, 2'd0, 12'h000, 9'd2, 1'b1, 1'b1);
    idle_chk("r40_done");

    issue(2'b01, 26'h0000180, 8'd0, 1'b0);
    sub("r41a", 12'h000, 2'd0, 12'h180, 9'd128, 1'b0, 1'b0);
    sub("r41b", 12'h000, 2'd1, 12'h000, 9'd128, 1'b1, 1'b0);
    idle_chk("r41_done");

    out_ready = 1'b0;
    issue(2'b00, 26'h00000FC, 8'd8, 1'b1);
    in_valid = 1'b1;
    in_addr = 26'h0000000;
    for (int i = 0; i < 5; i++) sub($sformatf("stall%0d", i), 12'h000, 2'd0, 12'h0FC, 9'd4, 1'b0, 1'b1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    sub("r42a", 12'h000, 2'd0, 12'h0FC, 9'd4, 1'b0, 1'b1);
    sub("r42b", 12'h000, 2'd1, 12'h000, 9'd4, 1'b1, 1'b1);
    idle_chk("r42_done");

    issue(2'b00, 26'h00000FC, 8'd8, 1'b0);
    sub("r43a", 12'h000, 2'd0, 12'h0FC, 9'd4, 1'b0, 1'b0);
    chk("r43b", {out_valid, out_bank, out_len}, {1'b1, 2'd1, 9'd4});
    sdram_rst = 1'b1;
    @(negedge sdram_clk);
    chk("r43_rst", {out_valid, out_bank, out_len, in_ready}, '0);
    sdram_rst = 1'b0;
    @(negedge sdram_clk);
    idle_chk("r43_rel");
    repeat (3) @(negedge sdram_clk);
    idle_chk("r43_quiet");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
